// File: rtl/unidade_controle_fsm.sv
// -----------------------------------------------------------------------------
// unidade_controle_fsm
//   Clocked load/store control unit. It accepts one decoded instruction at a
//   time through a valid/ready handshake, then sequences the data-RAM access:
//   it drives rd/we/address/data, captures loaded data into register A and
//   pulses flagUC (plus flagErro for an illegal opcode) when the instruction
//   completes. All outputs are registered.
//
//   Optional build macro: UC_MEM_ACK_EN
//     undefined : fixed RAM read latency of MEM_LAT cycles, no memAck port.
//     defined   : rd/we are held until memAck is sampled high; the CAP state
//                 is skipped and MEM_LAT is unused.
//
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   instrValid/Ready  instruction handshake (ready only in IDLE)
//   opcode, operando  instruction opcode and RAM address operand
//   regSaidaULA       ULA output register (store data)
//   dataOutMem        RAM read data
//   memAck            RAM access complete (UC_MEM_ACK_EN only)
//   rd, we            RAM read / write strobes
//   endMem, dataInMem RAM address and write data
//   regA              register A (load destination)
//   flagUC, flagErro  completion / illegal-opcode pulses
//
// state | meaning
// IDLE  | waiting for an instruction, instrReady = 1
// RD    | rd = 1, waiting for read latency (or memAck)
// CAP   | read data valid, regA captured at the closing edge
// WR    | we = 1 (one cycle, or until memAck)
// DONE  | flagUC (and flagErro) pulse
// -----------------------------------------------------------------------------
module unidade_controle_fsm #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] operando,
  input  logic [DATA_W-1:0] regSaidaULA,
  input  logic [DATA_W-1:0] dataOutMem,
`ifdef UC_MEM_ACK_EN
  input  logic              memAck,
`endif
  output logic              rd,
  output logic              we,
  output logic [ADDR_W-1:0] endMem,
  output logic [DATA_W-1:0] dataInMem,
  output logic [DATA_W-1:0] regA,
  output logic              flagUC,
  output logic              flagErro
);

  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_NOP   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] end_mem_q, end_mem_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic rd_q, rd_d;
  logic we_q, we_d;
  logic flag_uc_q, flag_uc_d;
  logic flag_erro_q, flag_erro_d;
  logic instr_ready_q, instr_ready_d;

`ifndef UC_MEM_ACK_EN
  // Down-counter loaded at accept; RD ends at terminal count zero, so RD
  // lasts exactly MEM_LAT cycles.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    end_mem_d   = end_mem_q;
    data_in_d   = data_in_q;
    reg_a_d     = reg_a_q;
    flag_erro_d = 1'b0;
`ifndef UC_MEM_ACK_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (instrValid) begin
          end_mem_d = operando;
          data_in_d = regSaidaULA;
`ifndef UC_MEM_ACK_EN
          cnt_d     = CNT_LOAD;
`endif
          case (opcode)
            OP_LOAD:  state_d = ST_RD;
            OP_STORE: state_d = ST_WR;
            OP_NOP:   state_d = ST_DONE;
            default: begin
              state_d     = ST_DONE;
              flag_erro_d = 1'b1;
            end
          endcase
        end
      end
      ST_RD: begin
`ifdef UC_MEM_ACK_EN
        if (memAck) begin
          reg_a_d = dataOutMem;
          state_d = ST_DONE;
        end
`else
        if (cnt_q == '0) state_d = ST_CAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
`endif
      end
      ST_CAP: begin
        reg_a_d = dataOutMem;
        state_d = ST_DONE;
      end
      ST_WR: begin
`ifdef UC_MEM_ACK_EN
        if (memAck) state_d = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rd_d          = (state_d == ST_RD);
    we_d          = (state_d == ST_WR);
    flag_uc_d     = (state_d == ST_DONE);
    instr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      end_mem_q     <= '0;
      data_in_q     <= '0;
      reg_a_q       <= '0;
      rd_q          <= 1'b0;
      we_q          <= 1'b0;
      flag_uc_q     <= 1'b0;
      flag_erro_q   <= 1'b0;
      instr_ready_q <= 1'b1;
`ifndef UC_MEM_ACK_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      end_mem_q     <= end_mem_d;
      data_in_q     <= data_in_d;
      reg_a_q       <= reg_a_d;
      rd_q          <= rd_d;
      we_q          <= we_d;
      flag_uc_q     <= flag_uc_d;
      flag_erro_q   <= flag_erro_d;
      instr_ready_q <= instr_ready_d;
`ifndef UC_MEM_ACK_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign instrReady = instr_ready_q;
  assign rd         = rd_q;
  assign we         = we_q;
  assign endMem     = end_mem_q;
  assign dataInMem  = data_in_q;
  assign regA       = reg_a_q;
  assign flagUC     = flag_uc_q;
  assign flagErro   = flag_erro_q;

endmodule

// File: tb/tb_unidade_controle_fsm.sv
// Bench for unidade_controle_fsm: instance A uses MEM_LAT=1, instance B uses
// MEM_LAT=3. A small RAM model returns read data one cycle after rd.
module tb_unidade_controle_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [3:0] opcode = 4'h0, operando = 4'h0;
  logic [7:0] ula = 8'h00;
  logic [7:0] dout_a = 8'h00, dout_b = 8'h00;
  logic       ack = 1'b0;

  logic       ready_a, rd_a, we_a, uc_a, erro_a;
  logic [3:0] end_a;
  logic [7:0] din_a, rega_a;
  logic       ready_b, rd_b, we_b, uc_b, erro_b;
  logic [3:0] end_b;
  logic [7:0] din_b, rega_b;

  logic [7:0] ram [16];

  int n_cmp = 0;
  int n_err = 0;
  int ovl   = 0;

  always #5 clk = ~clk;

  unidade_controle_fsm #(.DATA_W(8), .ADDR_W(4), .MEM_LAT(1)) dut_a (
    .clock(clk), .reset(rst), .instrValid(valid_a), .instrReady(ready_a),
    .opcode(opcode), .operando(operando), .regSaidaULA(ula), .dataOutMem(dout_a),
`ifdef UC_MEM_ACK_EN
    .memAck(ack),
`endif
    .rd(rd_a), .we(we_a), .endMem(end_a), .dataInMem(din_a), .regA(rega_a),
    .flagUC(uc_a), .flagErro(erro_a)
  );

  unidade_controle_fsm #(.DATA_W(8), .ADDR_W(4), .MEM_LAT(3)) dut_b (
    .clock(clk), .reset(rst), .instrValid(valid_b), .instrReady(ready_b),
    .opcode(opcode), .operando(operando), .regSaidaULA(ula), .dataOutMem(dout_b),
`ifdef UC_MEM_ACK_EN
    .memAck(ack),
`endif
    .rd(rd_b), .we(we_b), .endMem(end_b), .dataInMem(din_b), .regA(rega_b),
    .flagUC(uc_b), .flagErro(erro_b)
  );

  // RAM model: registered read while rd is high, write when we is high.
  always @(posedge clk) begin
    if (rd_a) dout_a <= ram[end_a];
    if (rd_b) dout_b <= ram[end_b];
    if (we_a) ram[end_a] <= din_a;
  end

  always @(negedge clk) begin
    if ((rd_a && we_a) || (rd_b && we_b)) ovl++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one instruction on instance A (called at a negedge, A idle) and
  // records what happens in cycles 1.. until instrReady returns.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] addr,
                           input logic [7:0] data, input int ack_cyc,
                           output int uc_cyc, output int rd_cnt, output int we_cnt,
                           output int first_rd, output int first_we,
                           output logic erro, output logic [7:0] rega_uc,
                           output logic [3:0] end_uc, output logic [7:0] din_uc,
                           output int ready_cyc, output int erro_stray);
    uc_cyc = 0; rd_cnt = 0; we_cnt = 0; first_rd = 0; first_we = 0;
    erro = 1'b0; rega_uc = 8'h00; end_uc = 4'h0; din_uc = 8'h00;
    ready_cyc = 0; erro_stray = 0;
    valid_a = 1'b1; opcode = op; operando = addr; ula = data;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0; opcode = ~op; operando = ~addr; ula = ~data;
    for (int c = 1; c <= 20 && ready_cyc == 0; c++) begin
      if (rd_a) begin rd_cnt++; if (first_rd == 0) first_rd = c; end
      if (we_a) begin we_cnt++; if (first_we == 0) first_we = c; end
      if (erro_a && !uc_a) erro_stray++;
      if (uc_a && uc_cyc == 0) begin
        uc_cyc = c; erro = erro_a; rega_uc = rega_a; end_uc = end_a; din_uc = din_a;
      end
      if (ack_cyc != 0) ack = (c == ack_cyc);
      if (ready_a) ready_cyc = c;
      else @(negedge clk);
    end
    ack = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] addr;
    logic [7:0] ula;
    int         e_uc;
    int         e_rd;
    int         e_we;
    logic       e_erro;
    logic [7:0] e_rega;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int uc_cyc, rd_cnt, we_cnt, first_rd, first_we, ready_cyc, stray;
    int last_rd;
    logic erro;
    logic [7:0] rega_uc, din_uc;
    logic [3:0] end_uc;

    for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
    ram[3] = 8'hA7;

    vecs[0] = '{4'hC, 4'hA, 8'h5C, 2, 0, 1, 1'b0, 8'h00};
    vecs[1] = '{4'hD, 4'h3, 8'h11, 3, 1, 0, 1'b0, 8'hA7};
    vecs[2] = '{4'h7, 4'h2, 8'h22, 1, 0, 0, 1'b1, 8'hA7};
    vecs[3] = '{4'h0, 4'h4, 8'h44, 1, 0, 0, 1'b0, 8'hA7};
    vecs[4] = '{4'hD, 4'hA, 8'h00, 3, 1, 0, 1'b0, 8'h5C};
    vecs[5] = '{4'hC, 4'hF, 8'hFF, 2, 0, 1, 1'b0, 8'h5C};
    vecs[6] = '{4'hD, 4'hF, 8'h66, 3, 1, 0, 1'b0, 8'hFF};
    vecs[7] = '{4'hF, 4'h1, 8'h77, 1, 0, 0, 1'b1, 8'hFF};
    vecs[8] = '{4'hE, 4'h0, 8'h88, 1, 0, 0, 1'b1, 8'hFF};
    vecs[9] = '{4'hD, 4'h0, 8'h99, 3, 1, 0, 1'b0, 8'h10};

    #12 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_a", ready_a, 1);
    chk("reset_rd_we_a", {rd_a, we_a}, 0);
    chk("reset_flags_a", {uc_a, erro_a}, 0);
    chk("reset_regs_a", {end_a, din_a, rega_a}, 0);
    chk("reset_ready_b", ready_b, 1);
    chk("reset_outs_b", {rd_b, we_b, uc_b, erro_b, end_b, din_b, rega_b}, 0);

    // Reset during LOAD cycle 1: rd must drop without a clock edge.
    valid_a = 1'b1; opcode = 4'hD; operando = 4'h3; ula = 8'h00;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    chk("midload_rd_before_reset", rd_a, 1);
    #1 rst = 1'b1;
    #1;
    chk("midload_rd_async_drop", rd_a, 0);
    chk("midload_rega", rega_a, 8'h00);
    chk("midload_ready_async", ready_a, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midload_idle_after", {ready_a, rd_a, uc_a, rega_a}, {1'b1, 1'b0, 1'b0, 8'h00});

    // Reset during STORE cycle 1: write aborted, RAM untouched.
    valid_a = 1'b1; opcode = 4'hC; operando = 4'h5; ula = 8'h33;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    chk("midstore_we_before_reset", we_a, 1);
    #1 rst = 1'b1;
    #1;
    chk("midstore_we_async_drop", we_a, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midstore_ram_untouched", ram[5], 8'h15);
    chk("midstore_idle_after", {ready_a, we_a, uc_a}, 3'b100);

`ifdef UC_MEM_ACK_EN
    // LOAD with memAck in cycle 4: rd for 4 cycles, flagUC in cycle 5.
    run_instr(4'hD, 4'h3, 8'h00, 4, uc_cyc, rd_cnt, we_cnt, first_rd, first_we,
              erro, rega_uc, end_uc, din_uc, ready_cyc, stray);
    chk("ack_load_rd_cycles", rd_cnt, 4);
    chk("ack_load_uc_cycle", uc_cyc, 5);
    chk("ack_load_rega", rega_uc, 8'hA7);
    chk("ack_load_ready_cycle", ready_cyc, 6);
    // STORE with memAck in cycle 2: we for 2 cycles, flagUC in cycle 3.
    run_instr(4'hC, 4'h8, 8'h4E, 2, uc_cyc, rd_cnt, we_cnt, first_rd, first_we,
              erro, rega_uc, end_uc, din_uc, ready_cyc, stray);
    chk("ack_store_we_cycles", we_cnt, 2);
    chk("ack_store_uc_cycle", uc_cyc, 3);
    chk("ack_store_rega_kept", rega_uc, 8'hA7);
    chk("ack_store_ram", ram[8], 8'h4E);
`else
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, vecs[i].addr, vecs[i].ula, 0, uc_cyc, rd_cnt, we_cnt,
                first_rd, first_we, erro, rega_uc, end_uc, din_uc, ready_cyc, stray);
      chk($sformatf("v%0d_uc_cycle", i), uc_cyc, vecs[i].e_uc);
      chk($sformatf("v%0d_rd_cycles", i), rd_cnt, vecs[i].e_rd);
      chk($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].e_we);
      chk($sformatf("v%0d_first_rd", i), first_rd, (vecs[i].e_rd != 0) ? 1 : 0);
      chk($sformatf("v%0d_first_we", i), first_we, (vecs[i].e_we != 0) ? 1 : 0);
      chk($sformatf("v%0d_erro", i), erro, vecs[i].e_erro);
      chk($sformatf("v%0d_erro_stray", i), stray, 0);
      chk($sformatf("v%0d_rega", i), rega_uc, vecs[i].e_rega);
      chk($sformatf("v%0d_endmem", i), end_uc, vecs[i].addr);
      chk($sformatf("v%0d_datainmem", i), din_uc, vecs[i].ula);
      chk($sformatf("v%0d_ready_cycle", i), ready_cyc, vecs[i].e_uc + 1);
    end

    // Back-to-back STORE then LOAD, valid held; opcode changed while busy.
    valid_a = 1'b1; opcode = 4'hC; operando = 4'h6; ula = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    opcode = 4'hD; ula = 8'h00;
    chk("b2b_c1_we_rd", {we_a, rd_a}, 2'b10);
    chk("b2b_c1_endmem_din", {end_a, din_a}, {4'h6, 8'h3C});
    @(negedge clk);
    chk("b2b_c2_uc", {uc_a, we_a, ready_a}, 3'b100);
    @(negedge clk);
    chk("b2b_c3_ready", ready_a, 1);
    @(negedge clk);
    valid_a = 1'b0;
    chk("b2b_c4_rd_we", {rd_a, we_a, ready_a}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_c6_uc_rega", {uc_a, rega_a}, {1'b1, 8'h3C});
    @(negedge clk);

    // MEM_LAT=3 LOAD on instance B: rd cycles 1..3, flagUC in cycle 5.
    valid_b = 1'b1; opcode = 4'hD; operando = 4'h3; ula = 8'h00;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0; opcode = 4'h0;
    rd_cnt = 0; last_rd = 0; uc_cyc = 0; ready_cyc = 0; rega_uc = 8'h00;
    for (int c = 1; c <= 12 && ready_cyc == 0; c++) begin
      if (rd_b) begin rd_cnt++; last_rd = c; end
      if (uc_b && uc_cyc == 0) begin uc_cyc = c; rega_uc = rega_b; end
      if (ready_b) ready_cyc = c;
      else @(negedge clk);
    end
    chk("lat3_rd_cycles", rd_cnt, 3);
    chk("lat3_last_rd", last_rd, 3);
    chk("lat3_uc_cycle", uc_cyc, 5);
    chk("lat3_rega", rega_uc, 8'hA7);
    chk("lat3_ready_cycle", ready_cyc, 6);
`endif

    chk("no_rd_we_overlap", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
